// File: rtl/tiny16_pkg.sv
// Shared definitions for the tiny16 issue/writeback slice: opcodes, flag bit
// positions, instruction field positions and the issue FSM state encoding.
package tiny16_pkg;

  localparam int DATA_W = 16;
  localparam int RA_W   = 3;

  // ALU opcodes; only the range OP_ADD..OP_SHR is executable.
  localparam logic [3:0] OP_ADD = 4'd3;
  localparam logic [3:0] OP_SUB = 4'd4;
  localparam logic [3:0] OP_MUL = 4'd5;
  localparam logic [3:0] OP_DIV = 4'd6;
  localparam logic [3:0] OP_AND = 4'd7;
  localparam logic [3:0] OP_OR  = 4'd8;
  localparam logic [3:0] OP_XOR = 4'd9;
  localparam logic [3:0] OP_SHL = 4'd10;
  localparam logic [3:0] OP_SHR = 4'd11;

  // Flag vector layout {O,C,N,Z}.
  localparam int FLG_O = 3;
  localparam int FLG_C = 2;
  localparam int FLG_N = 1;
  localparam int FLG_Z = 0;

  // Instruction fields: {op, rd, rs1, ar, imm_sel, imm4/rs2}.
  localparam int OP_MSB      = 15;
  localparam int OP_LSB      = 12;
  localparam int RD_MSB      = 11;
  localparam int RD_LSB      = 9;
  localparam int RS1_MSB     = 8;
  localparam int RS1_LSB     = 6;
  localparam int AR_BIT      = 5;
  localparam int IMM_SEL_BIT = 4;
  localparam int IMM_MSB     = 3;
  localparam int IMM_LSB     = 0;
  localparam int RS2_MSB     = 2;
  localparam int RS2_LSB     = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_CAPT = 2'd3
  } state_t;

  // True for opcodes the ALU is allowed to see.
  function automatic logic is_alu_op(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_SHR);
  endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Bundle of the instruction handshake, ALU drive/return, writeback, status
// and debug signals of alu_issue. master = environment, slave = alu_issue.
interface alu_issue_if #(
  parameter int DATA_W = 16,
  parameter int RA_W   = 3
);
  logic              instr_valid;
  logic [15:0]       instr;
  logic              instr_ready;
  logic [3:0]        alu_opcode;
  logic              alu_ar_flag;
  logic [DATA_W-1:0] alu_src1;
  logic [DATA_W-1:0] alu_src2;
  logic              alu_out_en;
  logic [DATA_W-1:0] alu_result;
  logic [3:0]        alu_flags;
  logic              wb_valid;
  logic [RA_W-1:0]   wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic [3:0]        flags_q;
  logic              err_illegal;
  logic              err_div0;
  logic [RA_W-1:0]   dbg_addr;
  logic [DATA_W-1:0] dbg_data;

  modport master (
    output instr_valid, instr, alu_result, alu_flags, dbg_addr,
    input  instr_ready, alu_opcode, alu_ar_flag, alu_src1, alu_src2, alu_out_en,
           wb_valid, wb_addr, wb_data, flags_q, err_illegal, err_div0, dbg_data
  );

  modport slave (
    input  instr_valid, instr, alu_result, alu_flags, dbg_addr,
    output instr_ready, alu_opcode, alu_ar_flag, alu_src1, alu_src2, alu_out_en,
           wb_valid, wb_addr, wb_data, flags_q, err_illegal, err_div0, dbg_data
  );
endinterface

// File: rtl/regfile8x16.sv
// 8x16 register file: two async operand read ports, one async debug read
// port, one synchronous write port. r0 always reads zero and ignores writes.
module regfile8x16 #(
  parameter int DATA_W = 16,
  parameter int RA_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [RA_W-1:0]   rd_addr1,
  output logic [DATA_W-1:0] rd_data1,
  input  logic [RA_W-1:0]   rd_addr2,
  output logic [DATA_W-1:0] rd_data2,
  input  logic [RA_W-1:0]   dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  input  logic              we,
  input  logic [RA_W-1:0]   wa,
  input  logic [DATA_W-1:0] wd
);
  localparam int NREG = 2 ** RA_W;

  logic [DATA_W-1:0] mem [NREG];

  // Register writes; r0 is never written so it stays at its reset value.
  // NOTE: every entry is asynchronously cleared, so this maps to flops rather than a RAM macro; that is deliberate for 8 entries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (we && (wa != '0)) begin
      // NOTE: sequential state is updated with <= so every reader sees the pre-edge value.
      mem[wa] <= wd;
    end
  end

  assign rd_data1 = (rd_addr1 == '0) ? '0 : mem[rd_addr1];
  assign rd_data2 = (rd_addr2 == '0) ? '0 : mem[rd_addr2];
  assign dbg_data = (dbg_addr == '0) ? '0 : mem[dbg_addr];

endmodule

// File: rtl/alu_issue.sv
// Issue/writeback stage in front of the tiny16 ALU. Accepts one instruction
// per 4 cycles, reads operands, drives the ALU for exactly one cycle, then
// writes the captured result and flags back. Divide-by-zero and non-ALU
// opcodes are trapped before the ALU is enabled.
// Optional feature: define ALU_ISSUE_IMM_EN to let imm_sel pick the
// zero-extended imm4 field as src2.
module alu_issue
  import tiny16_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int RA_W   = 3
) (
  input logic        clk,
  input logic        rst,
  alu_issue_if.slave bus
);

  state_t            state;
  logic [3:0]        op_q;
  logic [RA_W-1:0]   rd_q;
  logic [RA_W-1:0]   rs1_q;
  logic [RA_W-1:0]   rs2_q;
  logic              ar_q;
`ifdef ALU_ISSUE_IMM_EN
  logic              imm_sel_q;
  logic [3:0]        imm_q;
`endif

  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic [DATA_W-1:0] src2;
  logic              we;
  logic [RA_W-1:0]   wa;
  logic [DATA_W-1:0] wd;

  regfile8x16 #(.DATA_W(DATA_W), .RA_W(RA_W)) u_rf (
    .clk      (clk),
    .rst      (rst),
    .rd_addr1 (rs1_q),
    .rd_data1 (rd1),
    .rd_addr2 (rs2_q),
    .rd_data2 (rd2),
    .dbg_addr (bus.dbg_addr),
    .dbg_data (bus.dbg_data),
    .we       (we),
    .wa       (wa),
    .wd       (wd)
  );

`ifdef ALU_ISSUE_IMM_EN
  assign src2 = imm_sel_q ? DATA_W'(imm_q) : rd2;
`else
  assign src2 = rd2;
`endif

  assign bus.instr_ready = (state == ST_IDLE);

  // Register file write port: the divide-by-zero trap writes all-ones in
  // READ, a normal instruction writes the ALU result in CAPT.
  always_comb begin
    // NOTE: defaults first so no path leaves a signal unassigned and infers a latch.
    we = 1'b0;
    wa = rd_q;
    wd = bus.alu_result;
    if (state == ST_READ && op_q == OP_DIV && src2 == '0) begin
      we = 1'b1;
      wd = '1;
    end else if (state == ST_CAPT) begin
      we = 1'b1;
    end
  end

  // Issue FSM with registered ALU drive, writeback and error outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= ST_IDLE;
      op_q            <= '0;
      rd_q            <= '0;
      rs1_q           <= '0;
      rs2_q           <= '0;
      ar_q            <= 1'b0;
`ifdef ALU_ISSUE_IMM_EN
      imm_sel_q       <= 1'b0;
      imm_q           <= '0;
`endif
      bus.alu_opcode  <= '0;
      bus.alu_ar_flag <= 1'b0;
      bus.alu_src1    <= '0;
      bus.alu_src2    <= '0;
      bus.alu_out_en  <= 1'b0;
      bus.wb_valid    <= 1'b0;
      bus.wb_addr     <= '0;
      bus.wb_data     <= '0;
      bus.flags_q     <= '0;
      bus.err_illegal <= 1'b0;
      bus.err_div0    <= 1'b0;
    end else begin
      bus.wb_valid    <= 1'b0;
      bus.err_illegal <= 1'b0;
      bus.err_div0    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.instr_valid) begin
            op_q      <= bus.instr[OP_MSB:OP_LSB];
            rd_q      <= bus.instr[RD_MSB:RD_LSB];
            rs1_q     <= bus.instr[RS1_MSB:RS1_LSB];
            rs2_q     <= bus.instr[RS2_MSB:RS2_LSB];
            ar_q      <= bus.instr[AR_BIT];
`ifdef ALU_ISSUE_IMM_EN
            imm_sel_q <= bus.instr[IMM_SEL_BIT];
            imm_q     <= bus.instr[IMM_MSB:IMM_LSB];
`endif
            state     <= ST_READ;
          end
        end
        ST_READ: begin
          if (!is_alu_op(op_q)) begin
            bus.err_illegal <= 1'b1;
            state           <= ST_IDLE;
          end else if (op_q == OP_DIV && src2 == '0) begin
            bus.wb_valid <= 1'b1;
            bus.wb_addr  <= rd_q;
            bus.wb_data  <= '1;
            bus.err_div0 <= 1'b1;
            state        <= ST_IDLE;
          end else begin
            bus.alu_opcode  <= op_q;
            bus.alu_ar_flag <= ar_q;
            bus.alu_src1    <= rd1;
            bus.alu_src2    <= src2;
            bus.alu_out_en  <= 1'b1;
            state           <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          bus.alu_out_en <= 1'b0;
          state          <= ST_CAPT;
        end
        ST_CAPT: begin
          bus.wb_valid <= 1'b1;
          bus.wb_addr  <= rd_q;
          bus.wb_data  <= bus.alu_result;
          bus.flags_q  <= bus.alu_flags;
          state        <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue with a behavioural tiny16 ALU behind it.
// Expected writebacks are pushed to a scoreboard at issue time and popped
// when the DUT pulses wb_valid or err_illegal.
module tb_alu_issue;
  import tiny16_pkg::*;

  typedef enum logic [1:0] {K_WB, K_DIV0, K_ILL} kind_e;
  typedef struct {
    kind_e       kind;
    logic [2:0]  addr;
    logic [15:0] data;
    logic [3:0]  flags;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_issue_if bus ();
  alu_issue dut (.clk(clk), .rst(rst), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;
  exp_t sb[$];
  logic [15:0] ref_regs [8];
  logic [3:0]  ref_flags;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // tiny16 ALU behaviour: returns {O,C,N,Z, result}.
  function automatic logic [19:0] alu_fn(input logic [3:0] op, input logic ar,
                                         input logic [15:0] a, input logic [15:0] b);
    logic [16:0] w;
    logic [31:0] m;
    logic [15:0] r;
    logic c, o;
    r = '0; c = 1'b0; o = 1'b0; w = '0; m = '0;
    case (op)
      OP_ADD: begin
        w = {1'b0, a} + {1'b0, b}; r = w[15:0]; c = w[16];
        o = ar ? (a[15] == b[15] && r[15] != a[15]) : c;
      end
      OP_SUB: begin
        w = {1'b0, a} - {1'b0, b}; r = w[15:0]; c = w[16];
        o = ar ? (a[15] != b[15] && r[15] != a[15]) : c;
      end
      OP_MUL: begin m = a * b; r = m[15:0]; c = |m[31:16]; o = c; end
      OP_DIV: r = (b == '0) ? 16'hFFFF : a / b;
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      OP_SHL: r = a << b[3:0];
      OP_SHR: r = ar ? 16'($signed(a) >>> b[3:0]) : (a >> b[3:0]);
      default: r = '0;
    endcase
    return {o, c, r[15], (r == '0), r};
  endfunction

  // ALU model: samples on out_en, presents result the following cycle only.
  // Outside that cycle it drives a junk pattern standing in for tri-state.
  logic        alu_v;
  logic [15:0] alu_r;
  logic [3:0]  alu_f;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_v <= 1'b0; alu_r <= '0; alu_f <= '0;
    end else begin
      alu_v <= bus.alu_out_en;
      if (bus.alu_out_en) {alu_f, alu_r} <= alu_fn(bus.alu_opcode, bus.alu_ar_flag, bus.alu_src1, bus.alu_src2);
    end
  end
  assign bus.alu_result = alu_v ? alu_r : 16'hDEAD;
  assign bus.alu_flags  = alu_v ? alu_f : 4'b0101;

  function automatic logic [15:0] enc(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                                      input logic ar, input logic ims, input logic [3:0] lo);
    return {op, rd, rs1, ar, ims, lo};
  endfunction

  // Reference model: computes the expected outcome and updates model state.
  task automatic push(input logic [15:0] ins, output kind_e k);
    logic [3:0]  op;
    logic [2:0]  rd;
    logic [15:0] a, b;
    logic [19:0] res;
    exp_t e;
    op = ins[15:12];
    rd = ins[11:9];
    a  = ref_regs[ins[8:6]];
`ifdef ALU_ISSUE_IMM_EN
    b  = ins[4] ? {12'h000, ins[3:0]} : ref_regs[ins[2:0]];
`else
    b  = ref_regs[ins[2:0]];
`endif
    e.addr = rd; e.data = '0; e.flags = ref_flags;
    if (op < OP_ADD || op > OP_SHR) begin
      e.kind = K_ILL;
    end else if (op == OP_DIV && b == '0) begin
      e.kind = K_DIV0; e.data = 16'hFFFF;
      if (rd != 3'd0) ref_regs[rd] = 16'hFFFF;
    end else begin
      res = alu_fn(op, ins[5], a, b);
      e.kind = K_WB; e.data = res[15:0]; e.flags = res[19:16];
      ref_flags = res[19:16];
      if (rd != 3'd0) ref_regs[rd] = res[15:0];
    end
    sb.push_back(e);
    k = e.kind;
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (bus.wb_valid || bus.err_illegal)) begin
      if (sb.size() == 0) begin
        check("sb_nonempty", sb.size(), 1);
      end else begin
        e = sb.pop_front();
        if (bus.wb_valid) begin
          check("wb_kind", {31'd0, e.kind != K_ILL}, 1);
          check("wb_addr", bus.wb_addr, e.addr);
          check("wb_data", bus.wb_data, e.data);
          check("flags_q", bus.flags_q, e.flags);
          check("div0_flag", bus.err_div0, e.kind == K_DIV0);
        end else begin
          check("ill_kind", e.kind, K_ILL);
        end
      end
    end
  end

  // Issue one instruction and check handshake, timing and pulse widths.
  task automatic issue(input logic [15:0] ins);
    kind_e k;
    int n_en, n_wb, n_dz, n_il, wb_k;
    bit got;
    push(ins, k);
    @(negedge clk);
    bus.instr = ins;
    bus.instr_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.instr_ready) begin got = 1'b1; break; end
      @(negedge clk);
    end
    check("accept", {31'd0, got}, 1);
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;
    n_en = 0; n_wb = 0; n_dz = 0; n_il = 0; wb_k = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (bus.alu_out_en) n_en++;
      if (bus.wb_valid) begin n_wb++; if (wb_k == 0) wb_k = c; end
      if (bus.err_div0) n_dz++;
      if (bus.err_illegal) n_il++;
    end
    check("out_en_cycles", n_en, (k == K_WB) ? 1 : 0);
    check("wb_pulses", n_wb, (k == K_ILL) ? 0 : 1);
    check("div0_pulses", n_dz, (k == K_DIV0) ? 1 : 0);
    check("ill_pulses", n_il, (k == K_ILL) ? 1 : 0);
    // wb_valid is seen one half-cycle after the write edge: 3 edges for a
    // normal op, 1 edge for the divide-by-zero trap.
    if (k != K_ILL) check("wb_latency", wb_k - 1, (k == K_WB) ? 3 : 1);
  endtask

  task automatic dbg_check(input string tag, input int idx);
    @(negedge clk);
    bus.dbg_addr = idx[2:0];
    #1 check(tag, bus.dbg_data, ref_regs[idx]);
  endtask

  task automatic dbg_sweep();
    for (int i = 0; i < 8; i++) dbg_check("dbg_reg", i);
  endtask

  logic [15:0] misc [7];

  initial begin
    int acc;
    kind_e k;
    logic [15:0] ins;
    bus.instr_valid = 1'b0;
    bus.instr = '0;
    bus.dbg_addr = '0;
    for (int i = 0; i < 8; i++) ref_regs[i] = '0;
    ref_flags = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_ready", bus.instr_ready, 1);
    check("rst_out_en", bus.alu_out_en, 0);
    check("rst_opcode", bus.alu_opcode, 0);
    check("rst_src1", bus.alu_src1, 0);
    check("rst_src2", bus.alu_src2, 0);
    check("rst_wb_valid", bus.wb_valid, 0);
    check("rst_flags", bus.flags_q, 0);
    check("rst_errs", {bus.err_illegal, bus.err_div0}, 0);

    // Build operand values from an all-zero file.
    issue(enc(OP_DIV, 3'd6, 3'd0, 1'b0, 1'b0, 4'd0));  // r6 = FFFF (trap)
    issue(enc(OP_SUB, 3'd1, 3'd0, 1'b0, 1'b0, 4'd6));  // r1 = 1
    issue(enc(OP_ADD, 3'd2, 3'd1, 1'b0, 1'b0, 4'd1));  // r2 = 2
    issue(enc(OP_ADD, 3'd3, 3'd2, 1'b0, 1'b0, 4'd1));  // r3 = 3
    issue(enc(OP_ADD, 3'd4, 3'd2, 1'b0, 1'b0, 4'd3));  // r4 = 5

    // ADD 5 + 3.
    issue(enc(OP_ADD, 3'd5, 3'd4, 1'b0, 1'b0, 4'd3));
    bus.dbg_addr = 3'd5; #1 check("add_r5", bus.dbg_data, 16'h0008);
    check("add_flags", bus.flags_q, 4'b0000);

    // SUB 3 - 5.
    issue(enc(OP_SUB, 3'd7, 3'd3, 1'b0, 1'b0, 4'd4));
    bus.dbg_addr = 3'd7; #1 check("sub_r7", bus.dbg_data, 16'hFFFE);
    check("sub_flags", bus.flags_q, 4'b1110);

    // Divide by zero keeps flags.
    issue(enc(OP_DIV, 3'd5, 3'd4, 1'b0, 1'b0, 4'd0));
    bus.dbg_addr = 3'd5; #1 check("div0_r5", bus.dbg_data, 16'hFFFF);
    check("div0_flags", bus.flags_q, 4'b1110);

    // Normal divide, then illegal opcodes leave the file untouched.
    issue(enc(OP_DIV, 3'd5, 3'd7, 1'b0, 1'b0, 4'd2));
    issue(enc(4'hC, 3'd1, 3'd2, 1'b0, 1'b0, 4'd3));
    issue(enc(4'h0, 3'd2, 3'd2, 1'b0, 1'b0, 4'd3));
    issue(enc(4'hF, 3'd3, 3'd2, 1'b0, 1'b0, 4'd3));
    dbg_sweep();

    // Write to r0 is dropped but still reported.
    issue(enc(OP_ADD, 3'd0, 3'd1, 1'b0, 1'b0, 4'd1));
    bus.dbg_addr = 3'd0; #1 check("r0_zero", bus.dbg_data, 16'h0000);

    // Remaining opcodes; bit 3 set with imm_sel=0 must be ignored.
    misc[0] = enc(OP_MUL, 3'd6, 3'd4, 1'b0, 1'b0, 4'd4);
    misc[1] = enc(OP_AND, 3'd6, 3'd7, 1'b0, 1'b0, 4'd4);
    misc[2] = enc(OP_OR,  3'd6, 3'd7, 1'b0, 1'b0, 4'b1100);
    misc[3] = enc(OP_XOR, 3'd2, 3'd7, 1'b0, 1'b0, 4'd7);
    misc[4] = enc(OP_SHL, 3'd6, 3'd4, 1'b0, 1'b0, 4'd1);
    misc[5] = enc(OP_SHR, 3'd6, 3'd7, 1'b1, 1'b0, 4'd1);
    misc[6] = enc(OP_SHR, 3'd2, 3'd7, 1'b0, 1'b0, 4'd1);
    for (int i = 0; i < 7; i++) issue(misc[i]);
    dbg_sweep();

    // Immediate select (falls back to reg[7] when the feature is compiled out).
    issue(enc(OP_ADD, 3'd1, 3'd0, 1'b0, 1'b1, 4'hF));
    bus.dbg_addr = 3'd1;
`ifdef ALU_ISSUE_IMM_EN
    #1 check("imm_r1", bus.dbg_data, 16'h000F);
`else
    #1 check("noimm_r1", bus.dbg_data, ref_regs[7]);
`endif

    // Held instr_valid: one accept per 4 cycles.
    ins = enc(OP_ADD, 3'd3, 3'd3, 1'b0, 1'b0, 4'd1);
    @(negedge clk);
    bus.instr = ins;
    bus.instr_valid = 1'b1;
    acc = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.instr_ready) begin push(ins, k); acc++; end
      @(negedge clk);
    end
    bus.instr_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("thru_accepts", acc, 3);
    dbg_check("thru_r3", 3);

    // Async reset while the ALU is enabled.
    @(negedge clk);
    bus.instr = enc(OP_ADD, 3'd5, 3'd4, 1'b0, 1'b0, 4'd3);
    bus.instr_valid = 1'b1;
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("exec_out_en", bus.alu_out_en, 1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_out_en", bus.alu_out_en, 0);
    check("rst_mid_ready", bus.instr_ready, 1);
    check("rst_mid_wb", bus.wb_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) ref_regs[i] = '0;
    ref_flags = '0;
    repeat (5) @(negedge clk);
    check("rst_mid_flags", bus.flags_q, 0);
    dbg_sweep();

    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
- Issue/writeback stage that sits directly upstream of the tiny16 ALU.
- Accepts one 16-bit ALU instruction at a time through a valid/ready handshake, reads operands from an internal 8x16 register file, and drives the ALU's opcode/ar_flag/src1/src2/out_en.
- Captures the ALU's registered result and flags, then writes the result back to the register file.
- Guards the ALU against divide-by-zero and non-ALU opcodes.

Parameters:
- DATA_W, 16, datapath width; must match the ALU.
- RA_W, 3, register address width (2**RA_W registers).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- instr_valid  in  1  instruction offered.
- instr  in  16  {op[15:12], rd[11:9], rs1[8:6], ar[5], imm_sel[4], imm4/rs2[3:0]}.
- instr_ready  out  1  high only in IDLE.
- alu_opcode  out  4  to ALU opcode.
- alu_ar_flag  out  1  to ALU ar_flag.
- alu_src1  out  16  to ALU src1.
- alu_src2  out  16  to ALU src2.
- alu_out_en  out  1  to ALU out_en.
- alu_result  in  16  from ALU out.
- alu_flags  in  4  from ALU flags {O,C,N,Z}.
- wb_valid  out  1  one-cycle pulse on register write.
- wb_addr  out  3  destination of the write.
- wb_data  out  16  value written.
- flags_q  out  4  architectural flags {O,C,N,Z}.
- err_illegal  out  1  one-cycle pulse: opcode outside 3..11.
- err_div0  out  1  one-cycle pulse: DIV with src2==0.
- dbg_addr  in  3  debug read address.
- dbg_data  out  16  combinational register file read; r0 reads 0.

Behaviour:
- Reset (async, any state): state=IDLE; all 8 registers=0; all outputs 0 (alu_out_en=0, flags_q=0, pulses=0, alu_* buses=0).
- FSM states: IDLE, READ, EXEC, CAPT.
- IDLE: instr_ready=1. On edge E0 with instr_valid: latch instr, go to READ.
- READ: read rs1; src2 = rs2 register, or imm4 zero-extended when imm_sel=1. At E1:
  - opcode not in 3..11: err_illegal pulse, no write, go to IDLE.
  - opcode 6 and src2==0: write 16'hFFFF to rd, wb_valid pulse, err_div0 pulse, flags_q unchanged, ALU never enabled, go to IDLE.
  - otherwise: register alu_opcode/ar/src1/src2, alu_out_en<=1, go to EXEC.
- EXEC: alu_out_en high for exactly this one cycle; the ALU samples at E2. At E2: alu_out_en<=0, go to CAPT.
- CAPT: alu_result/alu_flags are valid. At E3: reg[rd]<=alu_result, flags_q<=alu_flags, wb_valid/wb_addr/wb_data pulse for one cycle, go to IDLE.
- Sample alu_result only in CAPT; outside CAPT the ALU output is tri-stated (Z).
- Latency and throughput: accept edge to writeback edge is 3 cycles; peak throughput is 1 instruction per 4 cycles.
- No RAW hazard: the earliest following READ starts after the write edge.
- r0 hardwired to zero:
  - reads return 0.
  - writes to rd=0 are dropped, but wb_valid still pulses (wb_addr=0) and flags_q still updates.
- alu_opcode/alu_src* hold their last value after EXEC. Only alu_out_en gates the ALU.
- instr is ignored while instr_ready=0.
- Reset mid-operation: the instruction is lost, no write, and no pulse occurs.
- In READ, bit 3 of the instruction is ignored when imm_sel=0.

Optional Feature:
- Macro: ALU_ISSUE_IMM_EN.
- Defined: imm_sel=1 selects the zero-extended imm4 as src2.
- Undefined: imm_sel is ignored; src2 is always reg[instr[2:0]]; no immediate mux is synthesized.

Decomposition:
- Package tiny16_pkg holds:
  - opcode localparams OP_ADD=3 through OP_SHR=11.
  - flag bit indices FLG_O=3, FLG_C=2, FLG_N=1, FLG_Z=0.
  - the FSM state enum.
  - instruction field position constants.
- One natural sub-module: regfile8x16. It has 2 async read ports (plus a debug read port) and 1 synchronous write port, r0 hardwired zero, and async reset to 0.
- The bench instantiates the real ALU behind alu_issue.

Test Plan:
- Handshake: after reset, instr_ready=1 and all outputs 0; instr_valid held while busy -> exactly one accept per 4 cycles.
- ADD: r1=5, r2=3; ADD rd=3 rs1=1 rs2=2 -> alu_out_en high exactly 1 cycle; wb_valid 3 cycles after accept; r3=16'h0008; flags_q=4'b0000.
- SUB: r1=3, r2=5; SUB rd=4 -> r4=16'hFFFE; flags_q=4'b1110.
- DIV by zero: r2=0; DIV rd=5 rs1=1 rs2=2 -> alu_out_en never asserts; r5=16'hFFFF; err_div0 pulse 1 cycle; flags_q unchanged.
- Illegal opcode: opcode 4'b1100 -> err_illegal pulse, no wb_valid, registers unchanged. Write to r0: r0 stays 0, wb_valid pulses.
- Async reset mid-EXEC: rst asserted between clock edges -> alu_out_en drops immediately, state IDLE, no writeback, all registers 0. With ALU_ISSUE_IMM_EN: ADD rd=1 rs1=0 imm4=4'hF -> r1=16'h000F.
